// File: rtl/fetch_pkg.sv
// Shared constants and helpers for the instruction-fetch front end.
package fetch_pkg;

   localparam logic [31:0] FETCH_RESET_PC = 32'h0000_0000;
   localparam logic [31:0] FETCH_NOP      = 32'h0000_0013;

   // Occupancy-style counters must hold 0..depth inclusive.
   function automatic int cnt_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with flush; used both as the pc tag FIFO and as the fetch queue.
module sync_fifo
   import fetch_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          flush,
   input  logic                          push,
   input  logic [WIDTH-1:0]              push_data,
   input  logic                          pop,
   output logic [WIDTH-1:0]              pop_data,
   output logic [cnt_width(DEPTH)-1:0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = cnt_width(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             full;
   logic             empty;
   logic             do_push;
   logic             do_pop;

   assign full  = (count == CW'(DEPTH));
   assign empty = (count == '0);

   // A pop on an empty FIFO is ignored; a push into a full FIFO needs a pop in the same cycle.
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] ptr);
      return (ptr == AW'(DEPTH - 1)) ? '0 : ptr + AW'(1);
   endfunction

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= ptr_next(wr_ptr);
         if (do_pop)  rd_ptr <= ptr_next(rd_ptr);
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

   // NOTE: storage has no reset; validity is tracked by count, so stale contents are never used.
   always_ff @(posedge clk) begin
      if (do_push && !flush) mem[wr_ptr] <= push_data;
   end

   assign pop_data = mem[rd_ptr];

endmodule

// File: rtl/fetch_buffer_unit.sv
// Instruction-fetch front end: PC, credit-limited in-order memory requests,
// a fetch queue toward decode, and redirect with discard of stale responses.
module fetch_buffer_unit
   import fetch_pkg::*;
#(
   parameter int               WIDTH    = 32,
   parameter int               DEPTH    = 4,
   parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(FETCH_RESET_PC)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             redirect_valid,
   input  logic [WIDTH-1:0] redirect_pc,
   output logic             imem_req_valid,
   output logic [WIDTH-1:0] imem_req_addr,
   input  logic             imem_req_ready,
   input  logic             imem_rsp_valid,
   input  logic [WIDTH-1:0] imem_rsp_data,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_pc,
   output logic [WIDTH-1:0] out_pcplus4,
   output logic [WIDTH-1:0] out_instr,
   input  logic             out_ready
);

   localparam int CW = cnt_width(DEPTH);

   logic [WIDTH-1:0]   fetch_pc;
   logic [CW-1:0]      occ;
   logic [CW-1:0]      outst;
   logic [CW-1:0]      drop;
   logic [CW-1:0]      drop_next;
   logic [CW:0]        credit_used;
   logic [WIDTH-1:0]   tag_pc;
   logic [2*WIDTH-1:0] head;
   logic [WIDTH-1:0]   head_pc;
   logic [WIDTH-1:0]   head_instr;
   logic [WIDTH-1:0]   redirect_aligned;
   logic               tag_full;
   logic               req_fire;
   logic               rsp_fire;
   logic               q_push;
   logic               out_fire;

   assign redirect_aligned = redirect_pc & ~WIDTH'(3);

   // Slots already claimed: queued entries plus responses still expected to be kept.
   assign credit_used = {1'b0, occ} + {1'b0, outst} - {1'b0, drop};

   // The tag FIFO is also bounded, since discarded responses still hold their tag until they return.
   assign tag_full = (outst == CW'(DEPTH));

   assign imem_req_valid = rst_n && !redirect_valid && !tag_full &&
                           (credit_used < (CW + 1)'(DEPTH));
   assign imem_req_addr  = fetch_pc;
   assign req_fire       = imem_req_valid && imem_req_ready;

   // Responses with nothing outstanding are protocol errors and are ignored.
   assign rsp_fire = imem_rsp_valid && (outst != '0);
   assign q_push   = rsp_fire && (drop == '0) && !redirect_valid;

   assign out_valid = (occ != '0);
   assign out_fire  = out_valid && out_ready;

   // NOTE: every combinational output gets a default first, so no path can infer a latch.
   always_comb begin
      drop_next = drop;
      if (redirect_valid) begin
         drop_next = outst - CW'(rsp_fire);
      end else if (rsp_fire && (drop != '0)) begin
         drop_next = drop - CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_pc <= RESET_PC;
         drop     <= '0;
      end else begin
         drop <= drop_next;
         if (redirect_valid) begin
            fetch_pc <= redirect_aligned;
         end else if (req_fire) begin
            fetch_pc <= fetch_pc + WIDTH'(4);
         end
      end
   end

   // Tags are never flushed: every pending response, kept or discarded, still pops its own tag.
   sync_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_tag_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (1'b0),
      .push      (req_fire),
      .push_data (fetch_pc),
      .pop       (rsp_fire),
      .pop_data  (tag_pc),
      .count     (outst)
   );

   sync_fifo #(
      .WIDTH (2 * WIDTH),
      .DEPTH (DEPTH)
   ) u_fetch_queue (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (redirect_valid),
      .push      (q_push),
      .push_data ({tag_pc, imem_rsp_data}),
      .pop       (out_fire),
      .pop_data  (head),
      .count     (occ)
   );

   assign head_pc    = head[2*WIDTH-1:WIDTH];
   assign head_instr = head[WIDTH-1:0];

   // Outputs read zero while empty so reset never exposes uninitialised storage.
   assign out_pc      = out_valid ? head_pc : '0;
   assign out_pcplus4 = out_valid ? head_pc + WIDTH'(4) : '0;
   assign out_instr   = out_valid ? head_instr : '0;

endmodule

// File: tb/tb_fetch_buffer_unit.sv
// Self-checking bench for fetch_buffer_unit: directed scenarios plus a randomized phase,
// all compared against a queue-based reference model and a behavioural instruction memory.
module tb_fetch_buffer_unit;

   localparam int          W = 32;
   localparam int          D = 4;
   localparam logic [31:0] K = 32'hA5A5_0000;

   typedef struct {
      logic [31:0] addr;
      int          due;
   } mreq_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        redirect_valid, imem_req_valid, imem_req_ready, imem_rsp_valid;
   logic        out_valid, out_ready;
   logic [31:0] redirect_pc, imem_req_addr, imem_rsp_data, out_pc, out_pcplus4, out_instr;

   logic        w_req_valid, w_rsp_valid, w_out_valid, w_out_ready;
   logic [31:0] w_req_addr, w_rsp_data, w_out_pc, w_out_pcplus4, w_out_instr;

   always #5 clk = ~clk;

   fetch_buffer_unit #(.WIDTH(W), .DEPTH(D), .RESET_PC(32'h0)) dut (
      .clk(clk), .rst_n(rst_n),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
      .imem_req_ready(imem_req_ready),
      .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
      .out_valid(out_valid), .out_pc(out_pc), .out_pcplus4(out_pcplus4),
      .out_instr(out_instr), .out_ready(out_ready)
   );

   fetch_buffer_unit #(.WIDTH(W), .DEPTH(D), .RESET_PC(32'hFFFF_FFF8)) dut_wrap (
      .clk(clk), .rst_n(rst_n),
      .redirect_valid(1'b0), .redirect_pc(32'h0),
      .imem_req_valid(w_req_valid), .imem_req_addr(w_req_addr),
      .imem_req_ready(1'b1),
      .imem_rsp_valid(w_rsp_valid), .imem_rsp_data(w_rsp_data),
      .out_valid(w_out_valid), .out_pc(w_out_pc), .out_pcplus4(w_out_pcplus4),
      .out_instr(w_out_instr), .out_ready(w_out_ready)
   );

   int errors = 0;
   int checks = 0;

   // Reference model: fetch queue, issued-but-unanswered tags, discard count, next PC.
   logic [31:0] m_q[$];
   logic [31:0] m_tags[$];
   int          m_drop;
   logic [31:0] m_pc;

   // Behavioural memory for the main DUT and a fixed 1-cycle memory for the wrap DUT.
   mreq_t       pend[$];
   int          last_due;
   int          cyc = 0;
   int          mem_lat = 1;
   bit          mem_rand = 1'b0;
   bit          mem_ready_rand = 1'b0;
   logic [1:0]  ready_mode = 2'd1;   // 0: hold off, 1: always ready, 2: random
   bit          w_fire;
   logic [31:0] w_addr;

   logic        s_req_valid, s_out_valid;
   logic [31:0] s_req_addr, s_out_pc;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_q.delete();
      m_tags.delete();
      pend.delete();
      m_drop   = 0;
      m_pc     = 32'h0;
      last_due = -1;
      w_fire   = 1'b0;
      w_addr   = 32'h0;
   endtask

   // Called just after a rising edge; returns just after the following one.
   task automatic do_reset();
      rst_n          = 1'b0;
      redirect_valid = 1'b0;
      imem_rsp_valid = 1'b0;
      w_rsp_valid    = 1'b0;
      @(posedge clk);
      #1;
      model_reset();
      rst_n = 1'b1;
   endtask

   // One clock cycle: drive inputs, sample and check at the falling edge, advance the model.
   task automatic cycle(input bit redir = 1'b0, input logic [31:0] rpc = 32'h0);
      bit          exp_rv, exp_ov, req_go, rsp_go, out_go;
      logic [31:0] pc;
      mreq_t       r;
      int          lat;
      redirect_valid = redir;
      redirect_pc    = rpc;
      out_ready      = (ready_mode == 2'd2) ? 1'($urandom_range(0, 1)) : ready_mode[0];
      imem_req_ready = mem_ready_rand ? 1'($urandom_range(0, 3) != 0) : 1'b1;
      if (pend.size() > 0 && pend[0].due <= cyc) begin
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = pend[0].addr ^ K;
         void'(pend.pop_front());
      end else begin
         imem_rsp_valid = 1'b0;
         imem_rsp_data  = $urandom;
      end
      w_rsp_valid = w_fire;
      w_rsp_data  = w_addr ^ K;

      @(negedge clk);
      exp_rv = !redir && (m_tags.size() < D) && ((m_q.size() + m_tags.size() - m_drop) < D);
      exp_ov = (m_q.size() != 0);
      check("req_valid", 32'(imem_req_valid), 32'(exp_rv));
      if (exp_rv) check("req_addr", imem_req_addr, m_pc);
      check("out_valid", 32'(out_valid), 32'(exp_ov));
      if (exp_ov) begin
         check("out_pc", out_pc, m_q[0]);
         check("out_pcplus4", out_pcplus4, m_q[0] + 32'd4);
         check("out_instr", out_instr, m_q[0] ^ K);
      end
      s_req_valid = imem_req_valid;
      s_req_addr  = imem_req_addr;
      s_out_valid = out_valid;
      s_out_pc    = out_pc;
      w_fire      = w_req_valid;
      w_addr      = w_req_addr;

      req_go = exp_rv && imem_req_ready;
      out_go = exp_ov && out_ready;
      rsp_go = imem_rsp_valid && (m_tags.size() > 0);
      if (out_go) void'(m_q.pop_front());
      if (rsp_go) begin
         pc = m_tags.pop_front();
         if (!redir) begin
            if (m_drop > 0) m_drop--;
            else m_q.push_back(pc);
         end
      end
      if (req_go) begin
         m_tags.push_back(m_pc);
         lat    = mem_rand ? int'($urandom_range(1, 4)) : mem_lat;
         r.addr = m_pc;
         r.due  = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
         last_due = r.due;
         pend.push_back(r);
         m_pc += 32'd4;
      end
      if (redir) begin
         m_q.delete();
         m_drop = m_tags.size();
         m_pc   = {rpc[31:2], 2'b00};
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "simulation did not finish");
   end

   initial begin
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      imem_req_ready = 1'b1;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
      out_ready      = 1'b0;
      w_rsp_valid    = 1'b0;
      w_rsp_data     = 32'h0;
      w_out_ready    = 1'b0;
      model_reset();

      // Reset state.
      repeat (2) @(negedge clk);
      check("rst_req_valid", 32'(imem_req_valid), 32'h0);
      check("rst_out_valid", 32'(out_valid), 32'h0);
      check("rst_out_pc", out_pc, 32'h0);
      check("rst_out_pcplus4", out_pcplus4, 32'h0);
      check("rst_out_instr", out_instr, 32'h0);
      check("rst_wrap_valid", 32'(w_out_valid), 32'h0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Streaming with a 1-cycle memory: one instruction per cycle from cycle 2.
      for (int i = 0; i < 8; i++) begin
         cycle();
         check("stream_valid", 32'(s_out_valid), 32'(i >= 2));
         if (i >= 2) check("stream_pc", s_out_pc, 32'((i - 2) * 4));
      end

      // PC wrap: the wrap instance has been held off and is now full.
      check("wrap_valid", 32'(w_out_valid), 32'h1);
      check("wrap_pc0", w_out_pc, 32'hFFFF_FFF8);
      check("wrap_pc0_plus4", w_out_pcplus4, 32'hFFFF_FFFC);
      check("wrap_instr0", w_out_instr, 32'hFFFF_FFF8 ^ K);
      w_out_ready = 1'b1;
      cycle();
      check("wrap_pc1", w_out_pc, 32'hFFFF_FFFC);
      check("wrap_pc1_plus4", w_out_pcplus4, 32'h0);
      cycle();
      check("wrap_pc2", w_out_pc, 32'h0);
      check("wrap_pc2_plus4", w_out_pcplus4, 32'h4);

      // Back-pressure: queue fills, requests stop, then drains in order.
      do_reset();
      ready_mode = 2'd0;
      repeat (10) cycle();
      check("bp_req_stopped", 32'(s_req_valid), 32'h0);
      check("bp_head_valid", 32'(s_out_valid), 32'h1);
      check("bp_head_pc", s_out_pc, 32'h0);
      ready_mode = 2'd1;
      for (int i = 0; i < 5; i++) begin
         cycle();
         check("bp_drain_pc", s_out_pc, 32'(i * 4));
      end

      // Redirect with two pending responses on a 3-cycle memory.
      do_reset();
      mem_lat = 3;
      cycle();
      cycle();
      cycle(1'b1, 32'h0000_0103);
      check("redir_no_req", 32'(s_req_valid), 32'h0);
      cycle();
      check("redir_req_valid", 32'(s_req_valid), 32'h1);
      check("redir_req_addr", s_req_addr, 32'h0000_0100);
      for (int i = 0; i < 20 && !s_out_valid; i++) cycle();
      check("redir_first_valid", 32'(s_out_valid), 32'h1);
      check("redir_first_pc", s_out_pc, 32'h0000_0100);

      // Redirect colliding with a response and an out handshake.
      do_reset();
      mem_lat = 1;
      repeat (4) cycle();
      cycle(1'b1, 32'h0000_0200);
      check("coll_handshake_valid", 32'(s_out_valid), 32'h1);
      check("coll_handshake_pc", s_out_pc, 32'h8);
      cycle();
      check("coll_flushed", 32'(s_out_valid), 32'h0);
      for (int i = 0; i < 20 && !s_out_valid; i++) cycle();
      check("coll_first_pc", s_out_pc, 32'h0000_0200);

      // Randomized traffic: variable latency, stalls, random redirects.
      do_reset();
      mem_rand       = 1'b1;
      mem_ready_rand = 1'b1;
      ready_mode     = 2'd2;
      for (int i = 0; i < 400; i++) cycle($urandom_range(0, 15) == 0, $urandom);
      mem_rand       = 1'b0;
      mem_ready_rand = 1'b0;

      // Reset mid-stream with three queued instructions.
      do_reset();
      ready_mode = 2'd0;
      repeat (4) cycle();
      check("mid_occ_head", out_pc, 32'h0);
      check("mid_occ_valid", 32'(out_valid), 32'h1);
      #2;
      rst_n = 1'b0;
      imem_rsp_valid = 1'b0;
      w_rsp_valid    = 1'b0;
      #1;
      check("mid_rst_out_valid", 32'(out_valid), 32'h0);
      check("mid_rst_out_pc", out_pc, 32'h0);
      check("mid_rst_out_pcplus4", out_pcplus4, 32'h0);
      check("mid_rst_out_instr", out_instr, 32'h0);
      check("mid_rst_req_valid", 32'(imem_req_valid), 32'h0);
      @(posedge clk);
      #1;
      model_reset();
      rst_n = 1'b1;
      ready_mode = 2'd1;
      cycle();
      check("restart_req_valid", 32'(s_req_valid), 32'h1);
      check("restart_req_addr", s_req_addr, 32'h0);
      repeat (4) cycle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/fetch_buffer_unit.md
# fetch_buffer_unit

Parametrised instruction-fetch front end: holds the program counter, issues in-order requests to an instruction memory with variable response latency, and buffers returned instructions in a DEPTH-entry queue for decode. It is the successor to the single-cycle PC/adder/memory fetch path. It adds:
- back-pressure from decode,
- credit-limited outstanding requests,
- redirect (branch/jump) with flush and discard of stale responses.

## Interface
- WIDTH, 32: address and instruction width.
- DEPTH, 4: fetch-queue entries; power of two, ≥2.
- RESET_PC, 0: PC loaded on reset; bits [1:0] must be 0.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- redirect_valid  in  1  branch/jump taken; flush and restart fetch.
- redirect_pc  in  WIDTH  new fetch address; bits [1:0] ignored (treated as 0).
- imem_req_valid  out  1  request valid.
- imem_req_addr  out  WIDTH  word-aligned fetch address.
- imem_req_ready  in  1  memory accepts the request this cycle.
- imem_rsp_valid  in  1  response valid; responses return in request order, latency ≥1 cycle.
- imem_rsp_data  in  WIDTH  instruction word.
- out_valid  out  1  queue head valid.
- out_pc  out  WIDTH  PC of the head instruction.
- out_pcplus4  out  WIDTH  out_pc+4, modulo 2^WIDTH.
- out_instr  out  WIDTH  head instruction.
- out_ready  in  1  decode consumes the head.

## Operation
**State**
- fetch_pc: next address to request.
- queue: storage of {pc, instr}.
- occ: queue occupancy, 0..DEPTH.
- outst: requests accepted but not yet answered.
- drop: count of responses still to be discarded.
- occ, outst and drop are each $clog2(DEPTH)+1 bits.

**Request**
- imem_req_valid = !redirect_valid && (occ + outst − drop) < DEPTH.
- imem_req_addr = fetch_pc.
- On a request handshake: fetch_pc += 4 (wraps modulo 2^WIDTH), outst += 1.
- A pc FIFO (DEPTH deep) records each issued address, to be paired with its response.

**Response**
- Each imem_rsp_valid decrements outst and pops the pc FIFO.
- If drop > 0: the data is discarded and drop −= 1.
- Otherwise: {pc, instr} is pushed into the queue.
- The credit rule guarantees the queue never overflows. A response with outst = 0 is a protocol error: ignore it and do not underflow.

**Output**
- out_valid = (occ ≠ 0).
- out_* are the head entry, driven from registers; no combinational path from imem_rsp_* to out_*.
- out_valid && out_ready pops the head.

**Redirect** (redirect_valid sampled at clock edge)
- fetch_pc ← {redirect_pc[WIDTH-1:2], 2'b00}.
- Queue flushed: occ ← 0.
- drop ← outst after this cycle's response is applied, i.e. every still-pending response is discarded.
- A response arriving in the redirect cycle is discarded.
- An out handshake in the same cycle counts as consumed; decode owns that instruction.
- No request is issued in the redirect cycle. Requests resume the next cycle, when credit allows.

## Timing
- Reset values: fetch_pc = RESET_PC, occ = outst = drop = 0, imem_req_valid = 0 while rst_n is low, out_valid = 0, out_pc/out_pcplus4/out_instr = 0.
- First request: imem_req_valid rises in the first cycle after rst_n deasserts.
- Latency with a 1-cycle memory: request at cycle n, response at n+1, out_valid at n+2.
- Steady state: one instruction per cycle when out_ready = 1 and the memory is always ready.
- Full queue: occ = DEPTH and out_ready = 0 → out_valid held and head stable.
- Empty queue: out_valid = 0 and out_instr is don't-care.
- Asserting rst_n mid-operation clears all state immediately. Responses to pre-reset requests must not be returned by the memory; the memory is reset by the same rst_n.

## Structure
- Package fetch_pkg: RESET_PC default, NOP encoding 32'h00000013, and a function computing the counter width.
- One sub-module, sync_fifo #(WIDTH, DEPTH), instantiated twice: the pc tag FIFO and the instruction queue (2*WIDTH wide).
- sync_fifo has:
  - a flush input;
  - push/pop with simultaneous push and pop allowed when full or empty;
  - pointers that wrap at DEPTH.

## Test plan
- **Streaming:** reset, RESET_PC = 0, 1-cycle memory returning instr = addr ^ 32'hA5A5_0000, out_ready = 1 → out_pc 0,4,8,C… one per cycle from cycle 2; out_pcplus4 = out_pc+4.
- **Back-pressure:** out_ready = 0 → occ reaches 4, then imem_req_valid = 0. Release → out_pc 0,4,8,C,10 in order with no loss.
- **Redirect with pending responses:** 3-cycle memory, 2 outstanding, redirect to 0x103 → both responses dropped, next imem_req_addr = 0x100, next out_pc = 0x100.
- **Redirect collisions:** redirect in the same cycle as imem_rsp_valid and an out handshake → response dropped, handshake counted, occ = 0 on the next cycle.
- **PC wrap:** RESET_PC = 32'hFFFF_FFF8 → out_pc FFFFFFF8, FFFFFFFC, 0; out_pcplus4 for FFFFFFFC = 0.
- **Reset mid-stream:** rst_n low for 1 cycle with occ = 3 → out_valid = 0 and outputs 0 at once; fetch restarts at RESET_PC.
